// File: rtl/io_key_switch_ctrl.sv
// io_key_switch_ctrl: synchronized, debounced KEY/SW input peripheral with data and ready/overrun/IE status registers
module io_key_switch_ctrl #(
    parameter int               DBITS           = 32,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter logic [DBITS-1:0] ADDR_KDATA      = 32'hF0000010,
    parameter logic [DBITS-1:0] ADDR_SDATA      = 32'hF0000014,
    parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110,
    parameter logic [DBITS-1:0] ADDR_SCTRL      = 32'hF0000114
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] addr,
    input  logic             rdEn,
    input  logic             wrtEn,
    input  logic [DBITS-1:0] dataIn,
    input  logic [3:0]       key,
    input  logic [9:0]       sw,
    output logic             sel,
    output logic [DBITS-1:0] dataOut,
    output logic             intr
);
    localparam int             CW     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [13:0]    RST_IN = 14'h000F;
    localparam logic [CW-1:0]  LAST   = CW'(DEBOUNCE_CYCLES - 1);

    logic [13:0]   s1, s2, deb, flip;
    logic [CW-1:0] cnt [14];
    logic [1:0]    chg, rd_clr, wr, ready, ovr, ie;
    logic          hit_kd, hit_sd, hit_kc, hit_sc;
    logic          unused_ok;

    assign hit_kd    = addr == ADDR_KDATA;
    assign hit_sd    = addr == ADDR_SDATA;
    assign hit_kc    = addr == ADDR_KCTRL;
    assign hit_sc    = addr == ADDR_SCTRL;
    assign chg       = {|flip[13:4], |flip[3:0]};
    assign rd_clr    = {rdEn && hit_sd, rdEn && hit_kd};
    assign wr        = {wrtEn && hit_sc, wrtEn && hit_kc};
    assign unused_ok = ^{dataIn[DBITS-1:5], dataIn[3], dataIn[1:0]};

    // a bit flips when its sync value has differed for the full debounce window
    always_comb begin
        flip = '0;
        for (int i = 0; i < 14; i++) flip[i] = (s2[i] != deb[i]) && (cnt[i] == LAST);
    end

    // two-flop synchronizer feeding per-bit debounce counters; bits 3:0 are keys, 13:4 switches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1  <= RST_IN;
            s2  <= RST_IN;
            deb <= RST_IN;
            for (int i = 0; i < 14; i++) cnt[i] <= '0;
        end else begin
            s1  <= {sw, key};
            s2  <= s1;
            deb <= deb ^ flip;
            for (int i = 0; i < 14; i++) cnt[i] <= (s2[i] != deb[i] && !flip[i]) ? cnt[i] + CW'(1) : '0;
        end
    end

    // status per group (0 = keys, 1 = switches); a consumed read suppresses overrun, a change beats a clearing write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready <= '0;
            ovr   <= '0;
            ie    <= '0;
            intr  <= 1'b0;
        end else begin
            for (int g = 0; g < 2; g++) begin
                ready[g] <= chg[g] | (ready[g] & ~rd_clr[g]);
                ovr[g]   <= (chg[g] & ready[g] & ~rd_clr[g]) | (ovr[g] & ~(wr[g] & ~dataIn[2]));
                ie[g]    <= wr[g] ? dataIn[4] : ie[g];
            end
            intr <= |(ie & ready);
        end
    end

    // combinational read mux, independent of rdEn
    always_comb begin
        sel     = hit_kd | hit_sd | hit_kc | hit_sc;
        dataOut = hit_kd ? {{(DBITS-4){1'b0}}, ~deb[3:0]} :
                  hit_sd ? {{(DBITS-10){1'b0}}, deb[13:4]} :
                  hit_kc ? {{(DBITS-5){1'b0}}, ie[0], 1'b0, ovr[0], 1'b0, ready[0]} :
                  hit_sc ? {{(DBITS-5){1'b0}}, ie[1], 1'b0, ovr[1], 1'b0, ready[1]} : '0;
    end
endmodule

// File: tb/tb_io_key_switch_ctrl.sv
// tb_io_key_switch_ctrl: directed scoreboard bench for io_key_switch_ctrl with DEBOUNCE_CYCLES=4
module tb_io_key_switch_ctrl;
    localparam logic [31:0] KD = 32'hF0000010;
    localparam logic [31:0] SD = 32'hF0000014;
    localparam logic [31:0] KC = 32'hF0000110;
    localparam logic [31:0] SC = 32'hF0000114;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic        rdEn = 1'b0;
    logic        wrtEn = 1'b0;
    logic [31:0] dataIn = '0;
    logic [3:0]  key = 4'hF;
    logic [9:0]  sw = '0;
    logic        sel;
    logic [31:0] dataOut;
    logic        intr;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    io_key_switch_ctrl #(.DBITS(32), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .addr(addr), .rdEn(rdEn), .wrtEn(wrtEn), .dataIn(dataIn),
        .key(key), .sw(sw), .sel(sel), .dataOut(dataOut), .intr(intr)
    );

    always #10 clk = ~clk;

    task automatic push(input string t, input logic [31:0] v);
        exp_t e;
        e.tag = t;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h with no expected value", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic peek(input logic [31:0] a, input string t, input logic [31:0] v);
        addr  = a;
        rdEn  = 1'b0;
        wrtEn = 1'b0;
        push(t, v);
        #1;
        pop_check(dataOut);
    endtask

    task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] v);
        push(t, v);
        pop_check(obs);
    endtask

    task automatic rd(input logic [31:0] a);
        addr = a;
        rdEn = 1'b1;
        @(negedge clk);
        rdEn = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr   = a;
        dataIn = d;
        wrtEn  = 1'b1;
        @(negedge clk);
        wrtEn = 1'b0;
    endtask

    initial begin
        tick(2);
        reset = 1'b1;
        tick(2);
        peek(KD, "rst_kdata", 32'h0);
        chk("rst_sel_kd", sel, 1);
        peek(SD, "rst_sdata", 32'h0);
        chk("rst_sel_sd", sel, 1);
        peek(KC, "rst_kctrl", 32'h0);
        chk("rst_sel_kc", sel, 1);
        tick(1);
        peek(SC, "rst_sctrl", 32'h0);
        chk("rst_sel_sc", sel, 1);
        chk("rst_intr", intr, 0);
        peek(32'hF0000018, "unmapped_data", 32'h0);
        chk("unmapped_sel", sel, 0);
        peek(32'hF0000011, "unaligned_data", 32'h0);
        chk("unaligned_sel", sel, 0);
        tick(1);
        key = 4'hD;
        tick(3);
        key = 4'hF;
        tick(8);
        peek(KD, "glitch_kdata", 32'h0);
        peek(KC, "glitch_kctrl", 32'h0);
        key = 4'hD;
        tick(5);
        peek(KD, "press_early_kdata", 32'h0);
        tick(1);
        peek(KD, "press_kdata", 32'h2);
        peek(KC, "press_kctrl", 32'h1);
        rd(KD);
        peek(KC, "press_cleared", 32'h0);
        key = 4'hF;
        tick(8);
        peek(KC, "release_kctrl", 32'h1);
        rd(KD);
        sw = 10'h3FF;
        tick(8);
        peek(SC, "sw_sctrl", 32'h1);
        addr = SD;
        rdEn = 1'b1;
        push("sw_sdata_rd", 32'h3FF);
        #1;
        pop_check(dataOut);
        @(negedge clk);
        rdEn = 1'b0;
        peek(SC, "sw_rd_clear", 32'h0);
        sw = 10'h001;
        tick(8);
        sw = 10'h003;
        tick(8);
        peek(SC, "overrun_sctrl", 32'h5);
        peek(SD, "overrun_sdata", 32'h3);
        wr(SC, 32'h0);
        peek(SC, "wr0_sctrl", 32'h1);
        sw = 10'h007;
        tick(8);
        peek(SC, "overrun2_sctrl", 32'h5);
        wr(SC, 32'h4);
        peek(SC, "wr4_sctrl", 32'h5);
        wr(SC, 32'h0);
        sw = 10'h00F;
        tick(5);
        wr(SC, 32'h0);
        peek(SC, "chg_beats_wr", 32'h5);
        wr(SC, 32'h0);
        rd(SD);
        peek(SC, "sctrl_idle", 32'h0);
        wr(KC, 32'h10);
        peek(KC, "ie_kctrl", 32'h10);
        key = 4'hE;
        tick(5);
        peek(KC, "ie_before", 32'h10);
        tick(1);
        peek(KC, "ie_ready", 32'h11);
        chk("intr_lag", intr, 0);
        tick(1);
        chk("intr_rise", intr, 1);
        rd(KD);
        peek(KC, "ie_rd_clear", 32'h10);
        chk("intr_hold", intr, 1);
        tick(1);
        chk("intr_fall", intr, 0);
        key = 4'hC;
        tick(8);
        peek(KC, "pre_collide", 32'h11);
        key = 4'h8;
        tick(5);
        rd(KD);
        peek(KC, "collide_kctrl", 32'h11);
        peek(KD, "collide_kdata", 32'h7);
        key = 4'hF;
        tick(3);
        #2;
        reset = 1'b0;
        peek(KD, "arst_kdata", 32'h0);
        peek(KC, "arst_kctrl", 32'h0);
        peek(SD, "arst_sdata", 32'h0);
        chk("arst_intr", intr, 0);
        sw = '0;
        tick(1);
        reset = 1'b1;
        tick(8);
        peek(KD, "post_rst_kdata", 32'h0);
        peek(KC, "post_rst_kctrl", 32'h0);
        if (sb.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/io_key_switch_ctrl.md
Name: io_key_switch_ctrl

Overview:
- Memory-mapped input peripheral for the KEY[3:0] pushbuttons and SW[9:0] switches of the single-cycle processor.
- Sits between the board pins and the data memory/IO read path.
- Synchronizes and debounces the raw inputs, then exposes data and control/status registers (ready, overrun, interrupt enable).
- Drives a read mux and an interrupt line that the data memory stage consumes.

Parameters:
DBITS, 32, data/address width
DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a debounced bit changes (>=2)
ADDR_KDATA, 32'hF0000010, key data register (read-only)
ADDR_SDATA, 32'hF0000014, switch data register (read-only)
ADDR_KCTRL, 32'hF0000110, key control/status register
ADDR_SCTRL, 32'hF0000114, switch control/status register

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
addr  in  DBITS  byte address from ALU output
rdEn  in  1  load in progress this cycle
wrtEn  in  1  store in progress this cycle
dataIn  in  DBITS  store data (rs2 value)
key  in  4  raw pushbuttons, active-low (0 = pressed)
sw  in  10  raw switches, active-high
sel  out  1  addr matches one of the four registers
dataOut  out  DBITS  read data
intr  out  1  interrupt request

Behaviour:
- Reset (reset==0, asynchronous): sync flops key=4'hF, sw=0; debounced key=4'hF, sw=0; all debounce counters 0; KCTRL=SCTRL=0; intr=0.
- Synchronizer: 2-flop per bit. Debounce input is the second flop, so raw-to-sync latency is 2 cycles.
- Debounce, per bit:
  - If sync != debounced, increment that bit's counter; otherwise clear it.
  - When the counter reaches DEBOUNCE_CYCLES-1 while sync still differs, the debounced bit takes the sync value next edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never propagates.
- Register contents:
  - KDATA = {28'b0, ~debounced_key}, so a pressed key reads 1.
  - SDATA = {22'b0, debounced_sw}.
- CTRL layout (KCTRL and SCTRL identical):
  - bit0 Ready: set on any debounced change of the group.
  - bit2 Overrun: set when a change occurs while Ready is already 1.
  - bit4 IE: interrupt enable, R/W.
  - All other bits read 0.
- Reads: combinational, same cycle as addr. dataOut is the selected register when sel is 1, otherwise 32'h0. rdEn does not gate dataOut.
- Read-clear: rdEn && addr==ADDR_KDATA clears KCTRL.Ready at the next edge. The same applies to SDATA/SCTRL.
- Simultaneous read-clear and new change, same cycle:
  - Ready stays 1.
  - Overrun is not set, because the old value was consumed.
- CTRL writes (wrtEn && addr==CTRL):
  - IE <= dataIn[4].
  - Overrun clears only if dataIn[2]==0; writing 1 leaves it unchanged.
  - Ready is unaffected by writes.
- Write vs. change in the same cycle: a change event setting Overrun wins over a write clearing it.
- Writes to DATA addresses and to unmapped addresses are ignored.
- Address decode: full 32-bit compare; unaligned addresses never match.
- intr is registered: intr <= (KCTRL.IE & KCTRL.Ready) | (SCTRL.IE & SCTRL.Ready). It is 1 cycle behind the status bits.
- rdEn and wrtEn both high: both actions take effect; they touch disjoint fields.
- Reset mid-debounce discards partial counts. Mid-overrun state clears to 0.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset held low, then released, key=4'hF, sw=0 -> read KDATA=0, SDATA=0, KCTRL=0, SCTRL=0, intr=0, sel=1 on each address; sel=0 and dataOut=0 at addr 32'hF0000018.
2. key[1] driven 0 for 3 cycles, then back to 1 -> KDATA stays 0, KCTRL.Ready=0. key[1] held 0 for 8 cycles -> KDATA=32'h2 and KCTRL=32'h1, exactly 2+4 cycles after the edge.
3. sw=10'h3FF held, then read SDATA -> dataOut=32'h3FF and SCTRL=1. The cycle after the read, SCTRL=0.
4. Change sw twice without reading -> SCTRL=32'h5. Write 32'h0 to SCTRL -> SCTRL=32'h1. Write 32'h4 -> Overrun stays as is.
5. Write 32'h10 to KCTRL, then press key[0] -> KCTRL=32'h11, intr=1 one cycle after Ready. Read KDATA -> Ready=0, and intr falls one cycle later.
6. Read KDATA in the same cycle as a new debounced key change -> KCTRL.Ready=1 and Overrun=0. Assert reset asynchronously mid-count -> all outputs return to reset values immediately.
